// File: rtl/net_resolve_bank.sv
// rtl/net_resolve_bank.sv - clocked bank of resolved 4-state nets (tri/wand/wor/trireg) with contention counting
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   drv_en          per channel/driver/bit enable (channel-major, then driver, then bit)
//   drv_val, drv_x  driven value, and X override per driver bit
//   clr_cnt         per-channel clear of the conflict counter
//   out_v/x/z       registered resolved value, X flag, Z flag per channel bit
//   conflict        registered per-channel 0/1 fight flag
//   conflict_cnt    per-channel saturating count of conflict cycles
module net_resolve_bank #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 8,
  parameter int NUM_DRV      = 3,
  parameter int RES_MODE     = 0,
  parameter int PULL         = 0,
  parameter int DECAY_CYCLES = 15,
  parameter int CNT_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH*NUM_DRV*WIDTH-1:0]  drv_en,
  input  logic [NUM_CH*NUM_DRV*WIDTH-1:0]  drv_val,
  input  logic [NUM_CH*NUM_DRV*WIDTH-1:0]  drv_x,
  input  logic [NUM_CH-1:0]                clr_cnt,
  output logic [NUM_CH*WIDTH-1:0]          out_v,
  output logic [NUM_CH*WIDTH-1:0]          out_x,
  output logic [NUM_CH*WIDTH-1:0]          out_z,
  output logic [NUM_CH-1:0]                conflict,
  output logic [NUM_CH*CNT_W-1:0]          conflict_cnt
);

  localparam int NB = NUM_CH * WIDTH;
  localparam int DW = (DECAY_CYCLES < 1) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DECAY_CYCLES);
  localparam logic IS_TRIREG = (RES_MODE == 3);
  // Reset outputs mirror the "no driver" resolution of the configured net type.
  localparam logic RST_X = IS_TRIREG;
  localparam logic RST_Z = !IS_TRIREG && (PULL == 0);
  localparam logic RST_V = (PULL == 2);

  generate
    if (PULL != 0 && RES_MODE == 3) begin : g_err_pull
      $error("net_resolve_bank: PULL must be 0 when RES_MODE is TRIREG");
    end
    if (NUM_DRV < 1) begin : g_err_drv
      $error("net_resolve_bank: NUM_DRV must be at least 1");
    end
  endgenerate

  logic [NB-1:0]          hold_v, hold_x;
  logic [NB-1:0]          nxt_v, nxt_x, nxt_z, nxt_hv, nxt_hx;
  logic [NUM_CH*DW-1:0]   dcnt, nxt_dcnt;
  logic [NUM_CH-1:0]      nxt_conf;
  logic [NUM_CH*CNT_W-1:0] nxt_cnt;

  always_comb begin
    logic any0, any1, anyx, rv, rx, rz, conf, active, decay;
    logic [DW-1:0] dc, dn;
    logic [CNT_W-1:0] cc;
    int idx;
    nxt_v    = '0;
    nxt_x    = '0;
    nxt_z    = '0;
    nxt_hv   = hold_v;
    nxt_hx   = hold_x;
    nxt_dcnt = dcnt;
    nxt_conf = '0;
    nxt_cnt  = conflict_cnt;
    any0 = 1'b0; any1 = 1'b0; anyx = 1'b0;
    rv = 1'b0; rx = 1'b0; rz = 1'b0;
    conf = 1'b0; active = 1'b0; decay = 1'b0;
    dc = '0; dn = '0; cc = '0; idx = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // Decay timer restarts whenever anything on the channel is driven.
      active = |drv_en[ch*NUM_DRV*WIDTH +: NUM_DRV*WIDTH];
      dc = dcnt[ch*DW +: DW];
      if (active)         dn = '0;
      else if (dc >= DMAX) dn = DMAX;
      else                dn = dc + 1'b1;
      nxt_dcnt[ch*DW +: DW] = dn;
      decay = (DECAY_CYCLES != 0) && (dn == DMAX);
      conf = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
        any0 = 1'b0; any1 = 1'b0; anyx = 1'b0;
        for (int d = 0; d < NUM_DRV; d++) begin
          idx = (ch * NUM_DRV + d) * WIDTH + b;
          if (drv_en[idx]) begin
            if (drv_x[idx])        anyx = 1'b1;
            else if (drv_val[idx]) any1 = 1'b1;
            else                   any0 = 1'b1;
          end
        end
        conf = conf | (any0 & any1);
        rv = 1'b0; rx = 1'b0; rz = 1'b0;
        if (!(any0 || any1 || anyx)) begin
          rz = 1'b1;
        end else if (RES_MODE == 1) begin
          if (any0)      rv = 1'b0;
          else if (anyx) rx = 1'b1;
          else           rv = 1'b1;
        end else if (RES_MODE == 2) begin
          if (any1)      rv = 1'b1;
          else if (anyx) rx = 1'b1;
          else           rv = 1'b0;
        end else begin
          if (anyx || (any0 && any1)) rx = 1'b1;
          else                        rv = any1;
        end
        idx = ch * WIDTH + b;
        if (IS_TRIREG) begin
          if (!rz) begin
            nxt_hv[idx] = rv;
            nxt_hx[idx] = rx;
          end else if (decay) begin
            nxt_hv[idx] = 1'b0;
            nxt_hx[idx] = 1'b1;
          end
          nxt_v[idx] = nxt_hx[idx] ? 1'b0 : nxt_hv[idx];
          nxt_x[idx] = nxt_hx[idx];
        end else begin
          if (rz && PULL != 0) begin
            nxt_v[idx] = (PULL == 2);
          end else begin
            nxt_v[idx] = rv;
            nxt_x[idx] = rx;
            nxt_z[idx] = rz;
          end
        end
      end
      nxt_conf[ch] = conf;
      cc = conflict_cnt[ch*CNT_W +: CNT_W];
      if (clr_cnt[ch])        cc = '0;
      else if (conf && !(&cc)) cc = cc + 1'b1;
      nxt_cnt[ch*CNT_W +: CNT_W] = cc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v        <= {NB{RST_V}};
      out_x        <= {NB{RST_X}};
      out_z        <= {NB{RST_Z}};
      conflict     <= '0;
      conflict_cnt <= '0;
      dcnt         <= '0;
      hold_v       <= '0;
      hold_x       <= '1;
    end else begin
      out_v        <= nxt_v;
      out_x        <= nxt_x;
      out_z        <= nxt_z;
      conflict     <= nxt_conf;
      conflict_cnt <= nxt_cnt;
      dcnt         <= nxt_dcnt;
      hold_v       <= nxt_hv;
      hold_x       <= nxt_hx;
    end
  end

endmodule

// File: tb/tb_net_resolve_bank.sv
// tb/tb_net_resolve_bank.sv - directed bench for net_resolve_bank in TRI, WAND+pull1 and TRIREG configurations
module tb_net_resolve_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] drv_en = '0, drv_val = '0, drv_x = '0;
  logic [3:0]  clr_cnt = '0;

  logic [31:0] t_v, t_x, t_z, w_v, w_x, w_z, r_v, r_x, r_z;
  logic [3:0]  t_conf, w_conf, r_conf;
  logic [31:0] t_cnt, w_cnt, r_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  net_resolve_bank u_tri (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .drv_x(drv_x), .clr_cnt(clr_cnt),
    .out_v(t_v), .out_x(t_x), .out_z(t_z), .conflict(t_conf), .conflict_cnt(t_cnt));

  net_resolve_bank #(.RES_MODE(1), .PULL(2)) u_wand (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .drv_x(drv_x), .clr_cnt(clr_cnt),
    .out_v(w_v), .out_x(w_x), .out_z(w_z), .conflict(w_conf), .conflict_cnt(w_cnt));

  net_resolve_bank #(.RES_MODE(3), .DECAY_CYCLES(3)) u_trg (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .drv_x(drv_x), .clr_cnt(clr_cnt),
    .out_v(r_v), .out_x(r_x), .out_z(r_z), .conflict(r_conf), .conflict_cnt(r_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drv();
    drv_en = '0; drv_val = '0; drv_x = '0;
  endtask

  task automatic drive(input int ch, input int d, input logic [7:0] v, input logic [7:0] x);
    drv_en[(ch*3+d)*8 +: 8]  = 8'hFF;
    drv_val[(ch*3+d)*8 +: 8] = v;
    drv_x[(ch*3+d)*8 +: 8]   = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_drv(); drive(0, 0, 8'h55, 8'h00);
    step(); step();
    total++; if (t_z !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_tri_z got=%h exp=ffffffff", t_z); end
    total++; if (t_x !== 32'h0 || t_v !== 32'h0) begin bad++; $display("FAIL reset_tri_vx got v=%h x=%h exp 0/0", t_v, t_x); end
    total++; if (t_conf !== 4'h0 || t_cnt !== 32'h0) begin bad++; $display("FAIL reset_tri_cnt got conf=%h cnt=%h exp 0/0", t_conf, t_cnt); end
    total++; if (w_v !== 32'hFFFFFFFF || w_z !== 32'h0) begin bad++; $display("FAIL reset_wand got v=%h z=%h exp ffffffff/0", w_v, w_z); end
    total++; if (r_x !== 32'hFFFFFFFF || r_z !== 32'h0) begin bad++; $display("FAIL reset_trireg got x=%h z=%h exp ffffffff/0", r_x, r_z); end
    rst = 1'b0; clear_drv();
  endtask

  task automatic test_tri_single();
    clear_drv(); drive(0, 0, 8'hA5, 8'h00);
    step();
    total++; if (t_v[7:0] !== 8'hA5) begin bad++; $display("FAIL tri_single_v got=%h exp=a5", t_v[7:0]); end
    total++; if (t_x[7:0] !== 8'h00 || t_z[7:0] !== 8'h00) begin bad++; $display("FAIL tri_single_xz got x=%h z=%h exp 0/0", t_x[7:0], t_z[7:0]); end
    total++; if (t_conf !== 4'h0) begin bad++; $display("FAIL tri_single_conf got=%h exp=0", t_conf); end
    total++; if (t_z[31:8] !== 24'hFFFFFF) begin bad++; $display("FAIL tri_idle_z got=%h exp=ffffff", t_z[31:8]); end
  endtask

  task automatic test_tri_conflict();
    clear_drv(); drive(1, 0, 8'hFF, 8'h00); drive(1, 1, 8'h0F, 8'h00);
    step();
    total++; if (t_x[15:8] !== 8'hF0) begin bad++; $display("FAIL tri_conf_x got=%h exp=f0", t_x[15:8]); end
    total++; if (t_v[11:8] !== 4'hF) begin bad++; $display("FAIL tri_conf_v got=%h exp=f", t_v[11:8]); end
    total++; if (t_conf !== 4'b0010) begin bad++; $display("FAIL tri_conf_flag got=%b exp=0010", t_conf); end
    total++; if (t_cnt[15:8] !== 8'd1) begin bad++; $display("FAIL tri_conf_cnt got=%0d exp=1", t_cnt[15:8]); end
    total++; if (w_conf !== 4'b0010) begin bad++; $display("FAIL wand_conf_flag got=%b exp=0010", w_conf); end
  endtask

  task automatic test_xdrv();
    clear_drv(); drive(2, 0, 8'h00, 8'hFF); drive(2, 1, 8'hFF, 8'h00);
    step();
    total++; if (t_x[23:16] !== 8'hFF) begin bad++; $display("FAIL xdrv_x got=%h exp=ff", t_x[23:16]); end
    total++; if (t_conf !== 4'h0) begin bad++; $display("FAIL xdrv_conf got=%b exp=0000", t_conf); end
  endtask

  task automatic test_wand();
    clear_drv();
    step();
    total++; if (w_v[7:0] !== 8'hFF || w_z[7:0] !== 8'h00) begin bad++; $display("FAIL wand_pull got v=%h z=%h exp ff/0", w_v[7:0], w_z[7:0]); end
    drive(0, 0, 8'hFE, 8'h00); drive(0, 1, 8'h7F, 8'h00);
    step();
    total++; if (w_v[7:0] !== 8'h7E || w_x[7:0] !== 8'h00) begin bad++; $display("FAIL wand_and got v=%h x=%h exp 7e/0", w_v[7:0], w_x[7:0]); end
    total++; if (w_conf[0] !== 1'b1) begin bad++; $display("FAIL wand_conf got=%b exp=1", w_conf[0]); end
    clear_drv(); drive(0, 0, 8'hFF, 8'h01); drive(0, 1, 8'hFF, 8'h00);
    step();
    total++; if (w_x[7:0] !== 8'h01 || w_v[7:1] !== 7'h7F) begin bad++; $display("FAIL wand_x got v=%h x=%h exp fe/01", w_v[7:0], w_x[7:0]); end
  endtask

  task automatic test_trireg_decay();
    clear_drv(); drive(0, 0, 8'h3C, 8'h00);
    step();
    total++; if (r_v[7:0] !== 8'h3C || r_x[7:0] !== 8'h00) begin bad++; $display("FAIL trg_drive got v=%h x=%h exp 3c/0", r_v[7:0], r_x[7:0]); end
    clear_drv();
    for (int i = 1; i <= 2; i++) begin
      step();
      total++; if (r_v[7:0] !== 8'h3C || r_x[7:0] !== 8'h00) begin bad++; $display("FAIL trg_hold%0d got v=%h x=%h exp 3c/0", i, r_v[7:0], r_x[7:0]); end
    end
    step();
    total++; if (r_x[7:0] !== 8'hFF) begin bad++; $display("FAIL trg_decay got x=%h exp=ff", r_x[7:0]); end
    step();
    total++; if (r_x[7:0] !== 8'hFF) begin bad++; $display("FAIL trg_decay_stay got x=%h exp=ff", r_x[7:0]); end
    drive(0, 0, 8'h55, 8'h00);
    step();
    total++; if (r_v[7:0] !== 8'h55 || r_x[7:0] !== 8'h00) begin bad++; $display("FAIL trg_redrive got v=%h x=%h exp 55/0", r_v[7:0], r_x[7:0]); end
  endtask

  task automatic test_saturate();
    clear_drv(); drive(1, 0, 8'hFF, 8'h00); drive(1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++) step();
    total++; if (t_cnt[15:8] !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", t_cnt[15:8]); end
    clr_cnt = 4'b0010;
    step();
    total++; if (t_cnt[15:8] !== 8'd0 || t_conf[1] !== 1'b1) begin bad++; $display("FAIL clr_cnt got cnt=%0d conf=%b exp 0/1", t_cnt[15:8], t_conf[1]); end
    clr_cnt = 4'b0000;
    step();
    total++; if (t_cnt[15:8] !== 8'd1) begin bad++; $display("FAIL clr_then_cnt got=%0d exp=1", t_cnt[15:8]); end
  endtask

  task automatic test_reset_mid();
    clear_drv(); drive(0, 0, 8'hAA, 8'h00);
    step();
    clear_drv();
    step();
    total++; if (r_v[7:0] !== 8'hAA || r_x[7:0] !== 8'h00) begin bad++; $display("FAIL mid_hold got v=%h x=%h exp aa/0", r_v[7:0], r_x[7:0]); end
    rst = 1'b1;
    step();
    total++; if (r_x !== 32'hFFFFFFFF) begin bad++; $display("FAIL mid_rst_x got=%h exp=ffffffff", r_x); end
    total++; if (t_cnt !== 32'h0) begin bad++; $display("FAIL mid_rst_cnt got=%h exp=0", t_cnt); end
    rst = 1'b0; drive(0, 0, 8'h11, 8'h00);
    step();
    total++; if (r_v[7:0] !== 8'h11 || r_x[7:0] !== 8'h00) begin bad++; $display("FAIL post_rst_drive got v=%h x=%h exp 11/0", r_v[7:0], r_x[7:0]); end
    total++; if (r_x[15:8] !== 8'hFF) begin bad++; $display("FAIL post_rst_uncharged got=%h exp=ff", r_x[15:8]); end
  endtask

  initial begin
    test_reset();
    test_tri_single();
    test_tri_conflict();
    test_xdrv();
    test_wand();
    test_trireg_decay();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
